// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its consumers.
package fetch_pkg;

  // Fetch sequencer states: issue a read, wait for its data, hand out two instructions.
  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DELIVER = 2'd2
  } fetch_state_t;

  // Size of one RV64 instruction and of one instruction-memory word.
  localparam int INSN_BYTES = 4;
  localparam int WORD_BYTES = 8;

  // Byte-offset widths derived from the sizes above.
  localparam int INSN_OFF_W = $clog2(INSN_BYTES);
  localparam int WORD_OFF_W = $clog2(WORD_BYTES);

  // Canonical RV64 NOP (addi x0, x0, 0); the decoder injects it as a bubble.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads 64-bit words from instruction memory one
// request at a time, and hands the two 32-bit instructions in each word to the
// decoder one per handshake. A redirect reloads the PC and discards any fetch
// already in flight so that stale instructions never reach the decoder.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  // instruction memory request channel (valid/ready)
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  // instruction memory response channel (valid only)
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_data,
  // instruction channel to the decoder
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  // redirect from downstream
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  // Sequencer state and datapath registers.
  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [63:0]       buf_reg, buf_next;
  logic              drop_reg, drop_next;

  // Registered outputs and their next values.
  logic              mem_req_valid_reg, mem_req_valid_next;
  logic [ADDR_W-1:0] mem_req_addr_reg, mem_req_addr_next;
  logic              ir_valid_reg, ir_valid_next;
  logic [31:0]       ir_reg, ir_next;
  logic [ADDR_W-1:0] ir_pc_reg, ir_pc_next;

  // Handshake qualifiers and derived addresses.
  logic              req_fire;
  logic              ir_fire;
  logic              req_stalled;
  logic [ADDR_W-1:0] redirect_pc_aligned;
  logic [ADDR_W-1:0] pc_inc;

  // Low redirect bits carry no information: targets are always 4-byte aligned.
  logic [INSN_OFF_W-1:0] unused_redirect_bits;

  assign req_fire            = mem_req_valid_reg && mem_req_ready;
  assign ir_fire             = ir_valid_reg && ir_ready;
  assign req_stalled         = (state_reg == REQ) && mem_req_valid_reg && !mem_req_ready;
  assign redirect_pc_aligned = {redirect_pc[ADDR_W-1:INSN_OFF_W], {INSN_OFF_W{1'b0}}};
  assign pc_inc              = pc_reg + ADDR_W'(INSN_BYTES);
  assign unused_redirect_bits = redirect_pc[INSN_OFF_W-1:0];

  // State register: sequencer, PC, word buffer, drop flag and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= REQ;
      pc_reg            <= RESET_PC;
      buf_reg           <= '0;
      drop_reg          <= 1'b0;
      mem_req_valid_reg <= 1'b0;
      mem_req_addr_reg  <= '0;
      ir_valid_reg      <= 1'b0;
      ir_reg            <= '0;
      ir_pc_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      buf_reg           <= buf_next;
      drop_reg          <= drop_next;
      mem_req_valid_reg <= mem_req_valid_next;
      mem_req_addr_reg  <= mem_req_addr_next;
      ir_valid_reg      <= ir_valid_next;
      ir_reg            <= ir_next;
      ir_pc_reg         <= ir_pc_next;
    end
  end

  // Next-state logic: sequencer transitions, PC advance/redirect, drop bookkeeping.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    buf_next   = buf_reg;
    drop_next  = drop_reg;

    unique case (state_reg)
      REQ: begin
        if (req_fire) begin
          // A request accepted in the redirect cycle already points at the old PC.
          state_next = WAIT;
          if (redirect_valid) begin
            drop_next = 1'b1;
          end
        end else if (redirect_valid && mem_req_valid_reg) begin
          // The offered request cannot be withdrawn; mark its data for discard now.
          drop_next = 1'b1;
        end
      end

      WAIT: begin
        if (mem_resp_valid) begin
          if (drop_reg || redirect_valid) begin
            // Stale word: throw it away and refetch at the (possibly new) PC.
            drop_next  = 1'b0;
            state_next = REQ;
          end else begin
            buf_next   = mem_resp_data;
            state_next = DELIVER;
          end
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end

      DELIVER: begin
        if (redirect_valid) begin
          // Any same-cycle handshake is void; the PC is simply replaced below.
          state_next = REQ;
        end else if (ir_fire) begin
          pc_next = pc_inc;
          // Leaving the upper half means the buffered word is exhausted.
          if (pc_reg[INSN_OFF_W]) begin
            state_next = REQ;
          end
        end
      end

      default: begin
        state_next = REQ;
      end
    endcase

    if (redirect_valid) begin
      pc_next = redirect_pc_aligned;
    end
  end

  // Output logic: next values of the registered request and instruction outputs.
  always_comb begin
    mem_req_valid_next = mem_req_valid_reg;
    mem_req_addr_next  = mem_req_addr_reg;
    ir_valid_next      = ir_valid_reg;
    ir_next            = ir_reg;
    ir_pc_next         = ir_pc_reg;

    if (state_next == REQ) begin
      // An offered-but-unaccepted request keeps its address, even across a redirect.
      if (!req_stalled) begin
        mem_req_valid_next = 1'b1;
        mem_req_addr_next  = {pc_next[ADDR_W-1:WORD_OFF_W], {WORD_OFF_W{1'b0}}};
      end
    end else begin
      mem_req_valid_next = 1'b0;
    end

    if (state_next == DELIVER) begin
      // Present a new instruction on entry or after a handshake; otherwise hold.
      if (state_reg != DELIVER || ir_fire) begin
        ir_valid_next = 1'b1;
        ir_next       = pc_next[INSN_OFF_W] ? buf_next[63:32] : buf_next[31:0];
        ir_pc_next    = pc_next;
      end
    end else begin
      ir_valid_next = 1'b0;
    end
  end

  assign mem_req_valid = mem_req_valid_reg;
  assign mem_req_addr  = mem_req_addr_reg;
  assign ir_valid      = ir_valid_reg;
  assign ir            = ir_reg;
  assign ir_pc         = ir_pc_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: drives memory and decoder handshakes
// cycle by cycle and checks every registered output against hand-computed values.
module tb_instruction_fetch;

  localparam int          ADDR_W   = 64;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_1000;

  logic              clk;
  logic              reset;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_data;
  logic              ir_valid;
  logic              ir_ready;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  int n_compared;
  int n_mismatched;

  instruction_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled and inputs changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One delivered instruction: valid, word and PC.
  task automatic expect_ir(input string tag, input logic [31:0] insn, input logic [63:0] pc);
    $display("ir  %-10s insn=%h pc=%h (valid=%0b)", tag, ir, ir_pc, ir_valid);
    check({tag, ".valid"}, 64'(ir_valid), 64'd1);
    check({tag, ".ir"}, 64'(ir), 64'(insn));
    check({tag, ".pc"}, ir_pc, pc);
  endtask

  // Request channel state: valid and (when valid) address.
  task automatic expect_req(input string tag, input logic valid, input logic [63:0] addr);
    $display("req %-10s valid=%0b addr=%h", tag, mem_req_valid, mem_req_addr);
    check({tag, ".req_valid"}, 64'(mem_req_valid), 64'(valid));
    if (valid) begin
      check({tag, ".req_addr"}, mem_req_addr, addr);
    end
  endtask

  initial begin
    n_compared     = 0;
    n_mismatched   = 0;
    reset          = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    ir_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values.
    tick();
    tick();
    check("rst.req_valid", 64'(mem_req_valid), 64'd0);
    check("rst.req_addr", mem_req_addr, 64'd0);
    check("rst.ir_valid", 64'(ir_valid), 64'd0);
    check("rst.ir", 64'(ir), 64'd0);
    check("rst.ir_pc", ir_pc, 64'd0);

    // First fetch at RESET_PC, 1-cycle memory latency, both halves back to back.
    reset = 1'b0;
    tick();
    expect_req("first", 1'b1, 64'h1000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    expect_req("wait0", 1'b0, 64'h0);
    check("wait0.ir_valid", 64'(ir_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h00A0_0513_0000_0013;
    tick();
    mem_resp_valid = 1'b0;
    ir_ready       = 1'b1;
    expect_ir("lo", 32'h0000_0013, 64'h1000);
    tick();
    expect_ir("hi", 32'h00A0_0513, 64'h1004);
    tick();
    check("next.ir_valid", 64'(ir_valid), 64'd0);
    expect_req("next", 1'b1, 64'h1008);

    // Redirect to 0x2004 in the same cycle the 0x1008 request is accepted.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2004;
    mem_req_ready  = 1'b1;
    tick();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b0;
    expect_req("rd1.wait", 1'b0, 64'h0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    check("rd1.drop.ir_valid", 64'(ir_valid), 64'd0);
    expect_req("rd1.req", 1'b1, 64'h2000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    ir_ready       = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h1111_1111_2222_2222;
    tick();
    mem_resp_valid = 1'b0;
    expect_ir("rd1.hi", 32'h1111_1111, 64'h2004);

    // Decoder backpressure for 5 cycles: instruction held, no new request.
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_ir("stall", 32'h1111_1111, 64'h2004);
      check("stall.req_valid", 64'(mem_req_valid), 64'd0);
    end
    ir_ready = 1'b1;
    tick();
    check("rd1.done.ir_valid", 64'(ir_valid), 64'd0);
    expect_req("rd1.next", 1'b1, 64'h2008);

    // Request stalled 3 cycles, redirect to 0x3000 in the second: address held.
    tick();
    expect_req("hold1", 1'b1, 64'h2008);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    expect_req("hold2", 1'b1, 64'h2008);
    tick();
    expect_req("hold3", 1'b1, 64'h2008);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    expect_req("rd2.wait", 1'b0, 64'h0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h7777_7777_8888_8888;
    tick();
    mem_resp_valid = 1'b0;
    check("rd2.drop.ir_valid", 64'(ir_valid), 64'd0);
    expect_req("rd2.req", 1'b1, 64'h3000);

    // Redirect to 0x4008 in the same cycle as the response: data discarded.
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h9999_9999_AAAA_AAAA;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4008;
    tick();
    mem_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    check("rd3.drop.ir_valid", 64'(ir_valid), 64'd0);
    expect_req("rd3.req", 1'b1, 64'h4008);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h4444_4444_3333_3333;
    tick();
    mem_resp_valid = 1'b0;
    expect_ir("rd3.lo", 32'h3333_3333, 64'h4008);

    // Redirect to 0x5004 in the same cycle as an ir handshake: handshake void.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h5004;
    tick();
    redirect_valid = 1'b0;
    check("rd4.void.ir_valid", 64'(ir_valid), 64'd0);
    expect_req("rd4.req", 1'b1, 64'h5000);

    // A response outside WAIT is ignored.
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hBBBB_BBBB_CCCC_CCCC;
    tick();
    mem_resp_valid = 1'b0;
    check("stray.ir_valid", 64'(ir_valid), 64'd0);
    expect_req("stray.req", 1'b1, 64'h5000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h5555_5555_6666_6666;
    tick();
    mem_resp_valid = 1'b0;
    expect_ir("rd4.hi", 32'h5555_5555, 64'h5004);
    tick();
    check("rd4.done.ir_valid", 64'(ir_valid), 64'd0);
    expect_req("rd4.next", 1'b1, 64'h5008);

    // Redirect during WAIT to the top of the address space; low bits ignored.
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    expect_req("rd5.wait", 1'b0, 64'h0);
    check("rd5.wait.ir_valid", 64'(ir_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hEEEE_EEEE_FFFF_FFFF;
    tick();
    mem_resp_valid = 1'b0;
    check("rd5.drop.ir_valid", 64'(ir_valid), 64'd0);
    expect_req("rd5.req", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hCAFE_BABE_0000_0000;
    tick();
    mem_resp_valid = 1'b0;
    expect_ir("top", 32'hCAFE_BABE, 64'hFFFF_FFFF_FFFF_FFFC);

    // PC wraps to zero after the last instruction.
    tick();
    check("wrap.ir_valid", 64'(ir_valid), 64'd0);
    expect_req("wrap", 1'b1, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
